// File: rtl/pbpix_zero_tagger.sv
// rtl/pbpix_zero_tagger.sv - zero-tagging pixel FIFO with frame boundary marking and per-frame zero count
module pbpix_zero_tagger #(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rstn,
    input  logic                               i_clear,
    input  logic                               src_rdy,
    output logic                               src_ack,
    input  logic [DW-1:0]                      src_data,
    output logic                               dst_rdy,
    input  logic                               dst_ack,
    output logic                               dst_zero,
    output logic [DW-1:0]                      dst_data,
    output logic                               dst_last,
    output logic                               frame_done,
    output logic [$clog2(FRAME_LEN+1)-1:0]     frame_zero_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(FRAME_LEN);
    localparam int ZW = $clog2(FRAME_LEN + 1);

    // Storage is never reset; the head is masked to 0 whenever the FIFO is empty.
    logic [DW-1:0]    mem_data_q [DEPTH];
    logic [DEPTH-1:0] mem_zero_q;
    logic [DEPTH-1:0] mem_last_q;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] in_pos_q, in_pos_d;
    logic [ZW-1:0] zacc_q, zacc_d;
    logic [ZW-1:0] fzc_q, fzc_d;
    logic          fdone_q, fdone_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic in_last;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    // Acceptance depends only on registered state, so dst_ack never reaches src_ack.
    assign src_ack  = src_rdy && !full && !i_clear;
    assign push     = src_ack;
    assign dst_rdy  = !empty;
    assign pop      = dst_rdy && dst_ack;
    assign in_last  = (in_pos_q == PW'(FRAME_LEN - 1));

    assign dst_data       = empty ? '0   : mem_data_q[rptr_q];
    assign dst_zero       = empty ? 1'b0 : mem_zero_q[rptr_q];
    assign dst_last       = empty ? 1'b0 : mem_last_q[rptr_q];
    assign frame_done     = fdone_q;
    assign frame_zero_cnt = fzc_q;

    // Next-state for pointers, occupancy, frame position and zero accounting; clear wins over push/pop.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        in_pos_d = in_pos_q;
        zacc_d   = zacc_q;
        fzc_d    = fzc_q;
        fdone_d  = 1'b0;
        if (i_clear) begin
            wptr_d   = '0;
            rptr_d   = '0;
            count_d  = '0;
            in_pos_d = '0;
            zacc_d   = '0;
        end else begin
            if (push) begin
                wptr_d   = wptr_q + AW'(1);
                in_pos_d = in_last ? '0 : in_pos_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
                if (dst_last) begin
                    fzc_d   = zacc_q + ZW'(dst_zero);
                    zacc_d  = '0;
                    fdone_d = 1'b1;
                end else begin
                    zacc_d  = zacc_q + ZW'(dst_zero);
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            in_pos_q <= '0;
            zacc_q   <= '0;
            fzc_q    <= '0;
            fdone_q  <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            in_pos_q <= in_pos_d;
            zacc_q   <= zacc_d;
            fzc_q    <= fzc_d;
            fdone_q  <= fdone_d;
        end
    end

    // FIFO entry write on every accepted word, tagging zero and frame-last.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data_q[wptr_q] <= src_data;
            mem_zero_q[wptr_q] <= (src_data == '0);
            mem_last_q[wptr_q] <= in_last;
        end
    end

endmodule
